modinv_seq: RTL
===============

# modinv_seq

Parametrised, multiplier-free modular-inverse engine: computes a⁻¹ mod n with the extended Euclidean algorithm.
- Each quotient is produced by a bit-serial restoring divider.
- The Bézout update is formed by shift-add alongside the divider.
- Reports gcd(a, n) and validity on every run.
- Sits alongside the Paillier key-generation and decryption datapaths (μ = L(g^λ mod n²)⁻¹ mod n) as their inverse unit.

## Interface
Parameters:
- WIDTH, 32: operand width of a, n and inverse. Legal range 8..256.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  value to invert; any value, including a ≥ n.
- n  in  WIDTH  modulus; unsigned.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when results are valid.
- valid  out  1  inverse exists; held until the next accepted start.
- inverse  out  WIDTH  a⁻¹ mod n, in range 0..n-1; 0 when valid=0.
- gcd  out  WIDTH  gcd(a, n); held with valid.
- iters  out  16  number of quotient steps k. Present only with MODINV_ITER_CNT_EN.

## Operation
- States: IDLE, LOAD, DIV, UPDATE, FIXUP.
- IDLE:
  - start=1 captures a and n, clears valid, inverse, gcd and iters, then goes to LOAD.
  - start is ignored while busy.
- LOAD:
  - r0=n, r1=a, t0=0, t1=1.
  - If n<2: go to FIXUP flagged invalid.
  - Else if r1==0: go to FIXUP.
  - Else: go to DIV.
- DIV: exactly WIDTH cycles, restoring division of r0 by r1, MSB first.
  - Each cycle shifts the partial remainder and fixes one quotient bit qb.
  - The same cycle does acc = 2·acc + (qb ? t1 : 0), so acc ends at q·t1.
  - Then go to UPDATE.
- UPDATE:
  - r0←r1, r1←remainder, t0←t1, t1←t0−acc; k increments.
  - If the new r1==0: go to FIXUP. Else: go to DIV.
- FIXUP:
  - gcd=r0.
  - valid=(r0==1 && !invalid).
  - inverse = t0<0 ? t0+n : t0 when valid; otherwise 0.
  - done=1 for this cycle only; go to IDLE.
- Arithmetic widths:
  - r0, r1 and the partial remainder are unsigned WIDTH.
  - t0, t1 and acc are signed WIDTH+2 (|t| ≤ n is guaranteed, so there is no overflow).
  - No hardware multiplier or divider is inferred.
- a ≥ n needs no pre-reduction: the first quotient is 0 and that step swaps the operands.
- a=0 or n<2: valid=0, inverse=0. gcd=n for a=0 with n≥2; gcd=0 when n<2.

## Timing
- Reset values: busy=0, done=0, valid=0, inverse=0, gcd=0, iters=0. State returns to IDLE.
- Reset mid-run aborts the run with no done pulse. start in the same cycle as reset is ignored.
- Latency, from the edge that samples start to the edge that raises done: 2 + k·(WIDTH+1) cycles.
- busy rises at the sampling edge and falls with done at the return to IDLE. done and busy are never both high.
- start held high continuously re-launches one cycle after done, using the a and n present then.
- Outputs stay stable between done and the next accepted start.

## Configuration
- MODINV_ITER_CNT_EN defined:
  - The iters port exists and reports k, saturating at 16'hFFFF.
  - It is cleared on accepted start and valid with done.
- MODINV_ITER_CNT_EN undefined:
  - The iters port and counter are absent.
  - All other behaviour and timing are identical.

## Test plan
- WIDTH=32, a=3, n=11: done at cycle 101; valid=1, inverse=4, gcd=1; iters=3 if enabled.
- a=14, n=11 (a ≥ n): k=5, done at cycle 167; valid=1, inverse=4, gcd=1.
- a=6, n=9: valid=0, inverse=0, gcd=3. Then a=0, n=9: done at cycle 2, valid=0, gcd=9. Then n=1: valid=0, gcd=0.
- Reset asserted in the middle of DIV: next cycle busy=0 and all outputs 0, with no done pulse. A fresh start with a=3, n=11 gives inverse=4.
- start pulsed while busy: ignored and the original result is unchanged. start held high: back-to-back runs with one IDLE cycle between done and the next busy.
- WIDTH=16, random coprime pairs: (a·inverse) mod n == 1 and inverse < n. Random non-coprime pairs: valid=0 and gcd matches the reference model.

Source files
------------

// File: rtl/modinv_seq.sv
// -----------------------------------------------------------------------------
// modinv_seq
// Multiplier-free modular inverse engine: a^-1 mod n via the extended Euclidean
// algorithm. Each quotient comes from a bit-serial restoring divider (WIDTH
// cycles), and the Bezout product q*t1 is built by shift-add in the same cycles.
//
// Parameters:
//   WIDTH    operand width of a, n, inverse and gcd (8..256)
// Ports:
//   clk      clock, rising edge
//   reset    synchronous active-high reset; clears all state and outputs
//   start    run request, sampled only while idle
//   a, n     value to invert and modulus (a may be >= n)
//   busy     high from the cycle after start is accepted until done
//   done     one-cycle pulse when results are valid
//   valid    inverse exists; held until the next accepted start
//   inverse  a^-1 mod n in 0..n-1, or 0 when valid=0
//   gcd      gcd(a, n); 0 when n < 2
//   iters    quotient step count k, saturating (only with MODINV_ITER_CNT_EN)
// Optional feature macro: MODINV_ITER_CNT_EN
// -----------------------------------------------------------------------------
module modinv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [WIDTH-1:0] inverse,
    output logic [WIDTH-1:0] gcd
`ifdef MODINV_ITER_CNT_EN
    ,
    output logic [15:0]      iters
`endif
);

    localparam int TW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DIV    = 3'd2,
        S_UPDATE = 3'd3,
        S_FIXUP  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       r0_q, r0_d, r1_q, r1_d, n_q, n_d;
    logic [WIDTH-1:0]       rem_q, rem_d, dvd_q, dvd_d;
    logic signed [TW-1:0]   t0_q, t0_d, t1_q, t1_d, acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   inv_flag_q, inv_flag_d;
    logic                   busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [WIDTH-1:0]       inverse_q, inverse_d, gcd_q, gcd_d;
`ifdef MODINV_ITER_CNT_EN
    logic [15:0]            k_q, k_d, iters_q, iters_d;
`endif

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    logic [WIDTH:0]         trial_s, diff_s;
    logic                   qb_s;
    logic signed [TW-1:0]   acc_step_s, inv_wrap_s;
    logic                   fix_valid_s;

    assign trial_s     = {rem_q, dvd_q[WIDTH-1]};
    assign diff_s      = trial_s - {1'b0, r1_q};
    assign qb_s        = (trial_s >= {1'b0, r1_q});
    // acc doubles each step and adds t1 for a set quotient bit, so it ends at q*t1.
    assign acc_step_s  = {acc_q[TW-2:0], 1'b0} + (qb_s ? t1_q : {TW{1'b0}});
    assign inv_wrap_s  = t0_q + $signed({2'b00, n_q});
    assign fix_valid_s = (r0_q == {{(WIDTH-1){1'b0}}, 1'b1}) && !inv_flag_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
                else       state_d = S_IDLE;
            end
            S_LOAD: begin
                if (n_q < WIDTH'(2))              state_d = S_FIXUP;
                else if (r1_q == {WIDTH{1'b0}})   state_d = S_FIXUP;
                else                              state_d = S_DIV;
            end
            S_DIV: begin
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_UPDATE;
                else                         state_d = S_DIV;
            end
            S_UPDATE: begin
                // rem_q is the remainder that becomes the new r1.
                if (rem_q == {WIDTH{1'b0}}) state_d = S_FIXUP;
                else                        state_d = S_DIV;
            end
            S_FIXUP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next-state values.
    always_comb begin
        r0_d       = r0_q;
        r1_d       = r1_q;
        n_d        = n_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        inv_flag_d = inv_flag_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        inverse_d  = inverse_q;
        gcd_d      = gcd_q;
`ifdef MODINV_ITER_CNT_EN
        k_d        = k_q;
        iters_d    = iters_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    r0_d      = n;
                    r1_d      = a;
                    n_d       = n;
                    busy_d    = 1'b1;
                    valid_d   = 1'b0;
                    inverse_d = {WIDTH{1'b0}};
                    gcd_d     = {WIDTH{1'b0}};
`ifdef MODINV_ITER_CNT_EN
                    k_d       = 16'd0;
                    iters_d   = 16'd0;
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_LOAD: begin
                t0_d       = TW'(0);
                t1_d       = TW'(1);
                dvd_d      = r0_q;
                rem_d      = {WIDTH{1'b0}};
                acc_d      = TW'(0);
                cnt_d      = CW'(0);
                inv_flag_d = (n_q < WIDTH'(2));
            end
            S_DIV: begin
                rem_d = qb_s ? diff_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                acc_d = acc_step_s;
                cnt_d = cnt_q + CW'(1);
            end
            S_UPDATE: begin
                r0_d  = r1_q;
                r1_d  = rem_q;
                t0_d  = t1_q;
                t1_d  = t0_q - acc_q;
                dvd_d = r1_q;
                rem_d = {WIDTH{1'b0}};
                acc_d = TW'(0);
                cnt_d = CW'(0);
`ifdef MODINV_ITER_CNT_EN
                k_d   = (k_q == 16'hFFFF) ? k_q : k_q + 16'd1;
`endif
            end
            S_FIXUP: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                valid_d = fix_valid_s;
                gcd_d   = inv_flag_q ? {WIDTH{1'b0}} : r0_q;
                if (fix_valid_s) begin
                    inverse_d = t0_q[TW-1] ? inv_wrap_s[WIDTH-1:0] : t0_q[WIDTH-1:0];
                end else begin
                    inverse_d = {WIDTH{1'b0}};
                end
`ifdef MODINV_ITER_CNT_EN
                iters_d = k_q;
`endif
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r0_q       <= {WIDTH{1'b0}};
            r1_q       <= {WIDTH{1'b0}};
            n_q        <= {WIDTH{1'b0}};
            rem_q      <= {WIDTH{1'b0}};
            dvd_q      <= {WIDTH{1'b0}};
            t0_q       <= TW'(0);
            t1_q       <= TW'(0);
            acc_q      <= TW'(0);
            cnt_q      <= CW'(0);
            inv_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            inverse_q  <= {WIDTH{1'b0}};
            gcd_q      <= {WIDTH{1'b0}};
`ifdef MODINV_ITER_CNT_EN
            k_q        <= 16'd0;
            iters_q    <= 16'd0;
`endif
        end else begin
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            n_q        <= n_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            inv_flag_q <= inv_flag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            inverse_q  <= inverse_d;
            gcd_q      <= gcd_d;
`ifdef MODINV_ITER_CNT_EN
            k_q        <= k_d;
            iters_q    <= iters_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign valid   = valid_q;
    assign inverse = inverse_q;
    assign gcd     = gcd_q;
`ifdef MODINV_ITER_CNT_EN
    assign iters   = iters_q;
`endif

endmodule
